fasta_base_streamer: RTL and testbench

//  Synthesizable FASTA front-end for the sw_gen_affine aligner.
//  - Consumes an ASCII byte stream.
//  - Captures the first record as the packed 2-bit query plus its length.
//  - Streams each following database record base by base with valid/ready.
//  - Flags the last base of every record and inserts idle gap cycles between records.

---
 rtl/fasta_base_streamer.sv | 256 +++++++++++++++++++++++++
 tb/tb_fasta_base_streamer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fasta_base_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : fasta_base_streamer
//  Description : FASTA front-end for the affine Smith-Waterman aligner.
//                The first record becomes a packed 2-bit query. Each later
//                record is streamed base by base over valid/ready, with the
//                last base of the record flagged and idle gap cycles inserted
//                between records.
//  Revision    : 1.0 - initial release
// ============================================================================
module fasta_base_streamer #(
   parameter int MAX_QLEN   = 50,
   parameter int LEN_W      = 6,
   parameter int GAP_CYCLES = 1,
   parameter int N_POLICY   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_char_vld,
   input  logic [7:0]              i_char,
   output logic                    o_char_rdy,
   input  logic                    i_eof,
   output logic [2*MAX_QLEN-1:0]   o_query,
   output logic [LEN_W-1:0]        o_query_length,
   output logic                    o_query_vld,
   output logic                    o_vld,
   output logic [1:0]              o_data,
   output logic                    o_last,
   input  logic                    i_rdy,
   output logic [15:0]             o_seq_count,
   output logic                    o_err_char,
   output logic                    o_err_qlen,
   output logic                    o_done
);

   typedef enum logic [2:0] {
      Q_HDR = 3'd0,
      Q_SEQ = 3'd1,
      D_HDR = 3'd2,
      D_SEQ = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                  state_q;
   logic [2*MAX_QLEN-1:0]   query_q;
   logic [LEN_W-1:0]        qlen_q;
   logic                    query_vld_q;
   logic                    hold_vld_q;
   logic [1:0]              hold_q;
   logic                    out_vld_q;
   logic [1:0]              out_data_q;
   logic                    out_last_q;
   logic                    eof_pend_q;
   logic [3:0]              gap_cnt_q;
   logic [15:0]             seq_count_q;
   logic                    err_char_q;
   logic                    err_qlen_q;
   logic                    done_q;

   logic                    char_rdy;
   logic                    byte_acc;
   logic                    eof_acc;
   logic                    is_lf;
   logic                    is_nl;
   logic                    is_gt;
   logic                    is_base;
   logic                    is_bad;
   logic                    take_base;
   logic [1:0]              base_code;

   // Classify the incoming byte: letters are matched case-insensitively by
   // clearing bit 5; anything that is not a base, a line break or '>' is bad.
   always_comb begin
      is_lf     = (i_char == 8'h0A);
      is_nl     = is_lf | (i_char == 8'h0D);
      is_gt     = (i_char == 8'h3E);
      is_base   = 1'b1;
      base_code = 2'b00;
      case (i_char & 8'hDF)
         8'h41:   base_code = 2'b00;   // A
         8'h47:   base_code = 2'b01;   // G
         8'h54:   base_code = 2'b10;   // T
         8'h43:   base_code = 2'b11;   // C
         default: is_base   = 1'b0;
      endcase
      is_bad    = !is_base && !is_nl && !is_gt;
      // A bad letter is either kept as A (code 00) or silently dropped.
      take_base = is_base || (is_bad && (N_POLICY == 0));
   end

   // Input ready: open in header/query states, gated by output back-pressure
   // while streaming, closed during the inter-record gap and after EOF.
   always_comb begin
      char_rdy = 1'b0;
      case (state_q)
         Q_HDR, Q_SEQ, D_HDR: char_rdy = 1'b1;
         D_SEQ:               char_rdy = !out_vld_q || i_rdy;
         default:             char_rdy = 1'b0;
      endcase
   end

   assign o_char_rdy = char_rdy && !rst;
   assign byte_acc   = i_char_vld && o_char_rdy && !i_eof;
   assign eof_acc    = i_char_vld && o_char_rdy && i_eof;

   // Main parser FSM with query packing, one-base hold register and the
   // registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= Q_HDR;
         query_q     <= '0;
         qlen_q      <= '0;
         query_vld_q <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_q      <= 2'b00;
         out_vld_q   <= 1'b0;
         out_data_q  <= 2'b00;
         out_last_q  <= 1'b0;
         eof_pend_q  <= 1'b0;
         gap_cnt_q   <= 4'd0;
         seq_count_q <= 16'd0;
         err_char_q  <= 1'b0;
         err_qlen_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         err_char_q <= 1'b0;

         // Default drain of the output register; later loads override it.
         if (out_vld_q && i_rdy) begin
            out_vld_q <= 1'b0;
            if (out_last_q) begin
               seq_count_q <= seq_count_q + 16'd1;
            end
         end

         case (state_q)
            Q_HDR: begin
               if (eof_acc) begin
                  query_vld_q <= 1'b1;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else if (byte_acc && is_lf) begin
                  state_q <= Q_SEQ;
               end
            end

            Q_SEQ: begin
               if (eof_acc) begin
                  query_vld_q <= 1'b1;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else if (byte_acc) begin
                  if (is_gt) begin
                     query_vld_q <= 1'b1;
                     state_q     <= D_HDR;
                  end else if (!is_nl) begin
                     err_char_q <= is_bad;
                     if (take_base) begin
                        if (qlen_q < LEN_W'(MAX_QLEN)) begin
                           for (int k = 0; k < MAX_QLEN; k++) begin
                              if (qlen_q == LEN_W'(k)) begin
                                 query_q[2*k +: 2] <= base_code;
                              end
                           end
                           qlen_q <= qlen_q + LEN_W'(1);
                        end else begin
                           err_qlen_q <= 1'b1;
                        end
                     end
                  end
               end
            end

            D_HDR: begin
               if (eof_acc) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (byte_acc && is_lf) begin
                  state_q <= D_SEQ;
               end
            end

            D_SEQ: begin
               if (eof_acc || (byte_acc && is_gt)) begin
                  if (hold_vld_q) begin
                     // Terminator: the held base leaves as the record's last beat.
                     out_vld_q  <= 1'b1;
                     out_data_q <= hold_q;
                     out_last_q <= 1'b1;
                     hold_vld_q <= 1'b0;
                     eof_pend_q <= eof_acc;
                     state_q    <= GAP;
                  end else if (eof_acc) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     // Empty record: no beats, no gap.
                     state_q <= D_HDR;
                  end
               end else if (byte_acc && !is_nl) begin
                  err_char_q <= is_bad;
                  if (take_base) begin
                     if (hold_vld_q) begin
                        out_vld_q  <= 1'b1;
                        out_data_q <= hold_q;
                        out_last_q <= 1'b0;
                     end
                     hold_q     <= base_code;
                     hold_vld_q <= 1'b1;
                  end
               end
            end

            GAP: begin
               if (out_vld_q) begin
                  // Gap count starts only once the last beat is taken.
                  if (i_rdy) begin
                     if (eof_pend_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        gap_cnt_q <= 4'(GAP_CYCLES - 1);
                     end
                  end
               end else if (gap_cnt_q == 4'd0) begin
                  state_q <= D_HDR;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
            end

            DONE: begin
               state_q <= DONE;
            end

            default: begin
               state_q <= Q_HDR;
            end
         endcase
      end
   end

   assign o_query        = query_q;
   assign o_query_length = qlen_q;
   assign o_query_vld    = query_vld_q;
   assign o_vld          = out_vld_q;
   assign o_data         = out_data_q;
   assign o_last         = out_last_q;
   assign o_seq_count    = seq_count_q;
   assign o_err_char     = err_char_q;
   assign o_err_qlen     = err_qlen_q;
   assign o_done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fasta_base_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fasta_base_streamer
//  Description : Scoreboard bench for fasta_base_streamer. Two instances:
//                A (GAP_CYCLES=1, N_POLICY=0) and B (GAP_CYCLES=3,
//                N_POLICY=1); the driver feeds whichever one is selected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fasta_base_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        tb_vld;
   logic [7:0]  tb_char;
   logic        tb_eof;
   logic        tb_rdy;
   int          sel;

   logic          rdy_a, qvld_a, vld_a, last_a, errc_a, errq_a, done_a;
   logic [99:0]   query_a;
   logic [5:0]    len_a;
   logic [1:0]    data_a;
   logic [15:0]   cnt_a;
   logic          rdy_b, qvld_b, vld_b, last_b, errc_b, errq_b, done_b;
   logic [99:0]   query_b;
   logic [5:0]    len_b;
   logic [1:0]    data_b;
   logic [15:0]   cnt_b;

   always #5 clk = ~clk;

   fasta_base_streamer #(.MAX_QLEN(50), .LEN_W(6), .GAP_CYCLES(1), .N_POLICY(0)) u_dut_a (
      .clk(clk), .rst(rst),
      .i_char_vld(tb_vld && sel == 0), .i_char(tb_char), .o_char_rdy(rdy_a), .i_eof(tb_eof),
      .o_query(query_a), .o_query_length(len_a), .o_query_vld(qvld_a),
      .o_vld(vld_a), .o_data(data_a), .o_last(last_a), .i_rdy(tb_rdy),
      .o_seq_count(cnt_a), .o_err_char(errc_a), .o_err_qlen(errq_a), .o_done(done_a)
   );

   fasta_base_streamer #(.MAX_QLEN(50), .LEN_W(6), .GAP_CYCLES(3), .N_POLICY(1)) u_dut_b (
      .clk(clk), .rst(rst),
      .i_char_vld(tb_vld && sel == 1), .i_char(tb_char), .o_char_rdy(rdy_b), .i_eof(tb_eof),
      .o_query(query_b), .o_query_length(len_b), .o_query_vld(qvld_b),
      .o_vld(vld_b), .o_data(data_b), .o_last(last_b), .i_rdy(tb_rdy),
      .o_seq_count(cnt_b), .o_err_char(errc_b), .o_err_qlen(errq_b), .o_done(done_b)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [2:0]  qa[$];
   logic [2:0]  qb[$];
   int          errcnt[2];
   logic        stall[2];
   logic [2:0]  prev[2];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor step for one instance: pops the scoreboard on each handshake,
   // checks that a stalled beat stays put and that input is blocked then.
   task automatic mon(input int id, input logic v, input logic [1:0] d, input logic l,
                      input logic cr, input logic ec);
      logic [2:0] e;
      if (ec) errcnt[id]++;
      if (v) begin
         if (stall[id]) chk($sformatf("hold_stable_%0d", id), {d, l}, prev[id]);
         if (tb_rdy) begin
            if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_beat_%0d: got %b expected no beat", id, {d, l});
            end else begin
               if (id == 0) e = qa.pop_front();
               else         e = qb.pop_front();
               chk($sformatf("beat_%0d", id), {d, l}, e);
            end
         end else begin
            chk($sformatf("rdy_in_stall_%0d", id), cr, 1'b0);
         end
      end
      stall[id] = v && !tb_rdy;
      prev[id]  = {d, l};
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall[0] = 1'b0;
         stall[1] = 1'b0;
      end else begin
         mon(0, vld_a, data_a, last_a, rdy_a, errc_a);
         mon(1, vld_b, data_b, last_b, rdy_b, errc_b);
      end
   end

   task automatic send(input logic [7:0] b, input logic eof);
      logic acc;
      int   t;
      acc = 1'b0;
      t   = 0;
      tb_vld = 1'b1; tb_char = b; tb_eof = eof;
      while (!acc && t < 300) begin
         @(negedge clk);
         acc = (sel == 0) ? rdy_a : rdy_b;
         @(posedge clk); #1;
         t++;
      end
      tb_vld = 1'b0; tb_eof = 1'b0; tb_char = 8'h00;
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: byte %h not accepted, required within 300 cycles", b);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reset both instances and confirm every output reads zero.
   task automatic reset_and_check();
      rst = 1'b1; tb_vld = 1'b0; tb_eof = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("reset_state_a", {query_a, len_a, qvld_a, vld_a, data_a, last_a, cnt_a, errc_a, errq_a, done_a, rdy_a}, '0);
      chk("reset_state_b", {query_b, len_b, qvld_b, vld_b, data_b, last_b, cnt_b, errc_b, errq_b, done_b, rdy_b}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      qa.delete();
      qb.delete();
      errcnt[0] = 0;
      errcnt[1] = 0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running, required $finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0]  letters [4];
      logic [1:0]  codes [4];
      logic [99:0] exp_q;
      int          g, t;

      letters = '{8'h41, 8'h43, 8'h47, 8'h54};   // A C G T
      codes   = '{2'b00, 2'b11, 2'b01, 2'b10};
      rst = 1'b1; tb_vld = 1'b0; tb_char = 8'h00; tb_eof = 1'b0; tb_rdy = 1'b1; sel = 0;
      reset_and_check();

      // Basic query + one two-base database record. Query ACGT packs to 9C.
      qa.push_back({2'b01, 1'b0});
      qa.push_back({2'b00, 1'b1});
      send_str(">q\nACGT\n>d\nGA\n");
      send(8'h00, 1'b1);
      wait_cyc(10);
      chk("t1_query", query_a, 100'h9C);
      chk("t1_len", len_a, 6'd4);
      chk("t1_qvld", qvld_a, 1'b1);
      chk("t1_count", cnt_a, 16'd1);
      chk("t1_done", done_a, 1'b1);
      chk("t1_rdy_done", rdy_a, 1'b0);
      chk("t1_drained", qa.size(), 0);

      // Downstream stall of 5 cycles in the middle of a record.
      reset_and_check();
      qa.push_back({2'b00, 1'b0});
      qa.push_back({2'b11, 1'b0});
      qa.push_back({2'b01, 1'b0});
      qa.push_back({2'b10, 1'b0});
      qa.push_back({2'b11, 1'b0});
      qa.push_back({2'b00, 1'b1});
      fork
         begin
            send_str(">q\nA\n>d\nACGTCA");
            send(8'h00, 1'b1);
         end
         begin
            t = 0;
            while (qa.size() > 4 && t < 500) begin
               @(negedge clk);
               t++;
            end
            @(posedge clk); #1;
            tb_rdy = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            tb_rdy = 1'b1;
         end
      join
      wait_cyc(10);
      chk("t2_count", cnt_a, 16'd1);
      chk("t2_len", len_a, 6'd1);
      chk("t2_done", done_a, 1'b1);
      chk("t2_drained", qa.size(), 0);

      // Empty record followed by a single-base record.
      reset_and_check();
      qa.push_back({2'b10, 1'b1});
      send_str(">q\nA\n>d\n>e\nT");
      send(8'h00, 1'b1);
      wait_cyc(10);
      chk("t3_count", cnt_a, 16'd1);
      chk("t3_done", done_a, 1'b1);
      chk("t3_drained", qa.size(), 0);

      // GAP_CYCLES=3 between two back-to-back records.
      sel = 1;
      reset_and_check();
      qb.push_back({2'b00, 1'b0});
      qb.push_back({2'b11, 1'b1});
      qb.push_back({2'b01, 1'b1});
      g = 0;
      fork
         begin
            send_str(">q\nA\n>d\nAC\n>e\nG");
            send(8'h00, 1'b1);
         end
         begin
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!(vld_b && last_b && tb_rdy) && t < 500);
            @(negedge clk);
            t = 0;
            while (!rdy_b && !vld_b && t < 50) begin
               g++;
               @(negedge clk);
               t++;
            end
         end
      join
      wait_cyc(10);
      chk("t4_gap_len", g, 3);
      chk("t4_count", cnt_b, 16'd2);
      chk("t4_done", done_b, 1'b1);
      chk("t4_drained", qb.size(), 0);

      // 52-base query: length saturates at 50, overflow flagged.
      sel = 0;
      reset_and_check();
      exp_q = '0;
      send_str(">q\n");
      for (int k = 0; k < 52; k++) begin
         send(letters[k % 4], 1'b0);
         if (k < 50) exp_q[2*k +: 2] = codes[k % 4];
      end
      send_str(">d\n");
      send(8'h00, 1'b1);
      wait_cyc(5);
      chk("t5_len", len_a, 6'd50);
      chk("t5_err_qlen", errq_a, 1'b1);
      chk("t5_query", query_a, exp_q);
      chk("t5_count_empty", cnt_a, 16'd0);
      chk("t5_done", done_a, 1'b1);

      // Non-ACGT letter, substitute policy.
      reset_and_check();
      qa.push_back({2'b00, 1'b0});
      qa.push_back({2'b00, 1'b0});
      qa.push_back({2'b11, 1'b1});
      send_str(">q\nA\n>d\nANc");
      send(8'h00, 1'b1);
      wait_cyc(10);
      chk("t6_err_pulses_a", errcnt[0], 1);
      chk("t6_count_a", cnt_a, 16'd1);
      chk("t6_drained_a", qa.size(), 0);

      // Non-ACGT letter, drop policy.
      sel = 1;
      reset_and_check();
      qb.push_back({2'b00, 1'b0});
      qb.push_back({2'b11, 1'b1});
      send_str(">q\nA\n>d\nANc");
      send(8'h00, 1'b1);
      wait_cyc(10);
      chk("t6_err_pulses_b", errcnt[1], 1);
      chk("t6_count_b", cnt_b, 16'd1);
      chk("t6_drained_b", qb.size(), 0);

      // Reset in the middle of a database record.
      sel = 0;
      reset_and_check();
      qa.push_back({2'b01, 1'b0});
      send_str(">q\nAC\n>d\nGG");
      wait_cyc(3);
      chk("t7_pre_reset_len", len_a, 6'd2);
      chk("t7_pre_reset_drained", qa.size(), 0);
      reset_and_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
